ghr_checkpoint_queue: RTL and testbench
=======================================

Name: ghr_checkpoint_queue

Overview:
- Speculative global branch history register with a circular checkpoint queue. Successor to the single-register BHR.
- The front end shifts predicted outcomes in speculatively. Each prediction allocates a tagged checkpoint holding the pre-update history.
- A mispredict restores history from its checkpoint and squashes younger entries. Retire pops the oldest entry into an architectural history.
- Sits between the predictor front end (pred_*), the branch unit (resolve_*) and commit (retire/flush).

Parameters:
- HIST_LEN, 8: history width in bits; must be >= 2.
- CKPT_DEPTH, 8: checkpoint entries; power of two, >= 2.
- TAG_W, $clog2(CKPT_DEPTH): derived; checkpoint tag width. Do not override.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- pred_valid  in  1  new predicted branch.
- pred_taken  in  1  predicted outcome (1 = taken).
- pred_ready  out  1  prediction accepted this cycle.
- pred_tag  out  TAG_W  tag allocated to the accepted prediction (= tail pointer).
- resolve_valid  in  1  branch resolution.
- resolve_tag  in  TAG_W  tag being resolved.
- resolve_mispredict  in  1  resolution disagrees with the prediction.
- resolve_taken  in  1  actual outcome.
- retire_valid  in  1  pop oldest checkpoint.
- flush  in  1  discard all speculative state.
- spec_hist  out  HIST_LEN  speculative history.
- arch_hist  out  HIST_LEN  committed history.
- ckpt_count  out  TAG_W+1  occupied entries.
- full  out  1  ckpt_count == CKPT_DEPTH.
- empty  out  1  ckpt_count == 0.

Behaviour:
- Reset (asynchronous, any time): spec_hist = 0, arch_hist = 0, head = tail = 0, ckpt_count = 0, all entry valid bits = 0. Outputs at reset: empty = 1, full = 0, pred_ready = 1, pred_tag = 0.
- Entry contents: hist[HIST_LEN], outcome bit, valid bit.
- Shift rule, for all histories: new = {old[HIST_LEN-2:0], bit}. Newest bit is in the LSB; the MSB is discarded.
- pred_ready (combinational) = !full && !flush && !(resolve_valid && resolve_mispredict && entry valid). pred_tag = tail, combinational.
- Predict accept (pred_valid && pred_ready), at the clock edge:
  - entry[tail] <= {spec_hist (pre-update), pred_taken, valid = 1}.
  - tail++ (mod CKPT_DEPTH).
  - spec_hist <= shift(spec_hist, pred_taken).
  - Latency: 1 cycle to spec_hist.
- pred_valid with pred_ready = 0: dropped, no state change.
- Resolve with resolve_mispredict = 0: no state change.
- Resolve on a tag whose valid bit = 0: ignored entirely.
- Mispredict (resolve_valid && resolve_mispredict && entry[t].valid):
  - spec_hist <= shift(entry[t].hist, resolve_taken).
  - entry[t].outcome <= resolve_taken.
  - Clear valid on all entries younger than t.
  - tail <= t+1; ckpt_count recomputed.
  - Entry t itself stays valid.
- Retire (retire_valid && !empty):
  - arch_hist <= shift(arch_hist, entry[head].outcome).
  - entry[head].valid <= 0; head++.
  - If a mispredict targets head in the same cycle, use the corrected resolve_taken (bypass).
- Retire on empty: ignored.
- Simultaneous retire + mispredict: both apply. Count = (count after squash) - 1.
- Simultaneous retire + predict: both apply; count unchanged. Predict is never accepted while full, even if a retire occurs the same cycle.
- Priority: reset > flush > mispredict > predict. Retire is independent except under flush.
- Flush: spec_hist <= arch_hist (value after any same-cycle retire is NOT applied; retire is ignored under flush). All valid bits cleared, head = tail = 0, count = 0.
- Pointer wrap: tags wrap CKPT_DEPTH-1 -> 0. Tags are reused only after the entry is retired or squashed.
- Outputs full, empty, ckpt_count are registered-state derived, with no combinational input paths.

Test Plan:
All scenarios use HIST_LEN=4, CKPT_DEPTH=4.
1. Reset: assert reset mid-cycle -> spec_hist=0000, arch_hist=0000, ckpt_count=0, empty=1, full=0, pred_ready=1, pred_tag=0.
2. Predict T,N,T,T on consecutive cycles -> pred_tag 0,1,2,3; spec_hist 0001,0010,0101,1011; full=1. Then a 5th pred_valid -> pred_ready=0; spec_hist stays 1011; count stays 4.
3. After scenario 2, mispredict tag=1 with taken=1 -> spec_hist=0011 (checkpoint 0001 shifted with 1); ckpt_count=2; entries 2,3 invalid; next pred_tag=2. A later resolve on tag 3 is ignored.
4. After scenario 3, retire two cycles -> arch_hist 0001 then 0011; empty=1. A third retire_valid is ignored.
5. Wrap: 6 predict/retire pairs alternating -> tags 0,1,2,3,0,1; ckpt_count never exceeds 1; arch_hist equals the last 4 predicted bits.
6. Predict T,T,N (spec=0110, arch=0000), then flush together with retire_valid and pred_valid -> spec_hist=0000, arch_hist=0000, count=0, pred_ready=0 that cycle. Next cycle pred_tag=0.

Source files
------------

// File: rtl/ghr_checkpoint_queue.sv
// Speculative global branch history register with a circular checkpoint queue.
// Each accepted prediction saves the pre-update history in a tagged entry.
// A mispredict restores history from that entry and squashes every younger entry.
// Retire pops the oldest entry's outcome into the architectural history.
module ghr_checkpoint_queue #(
  parameter int HIST_LEN   = 8,
  parameter int CKPT_DEPTH = 8,
  parameter int TAG_W      = $clog2(CKPT_DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pred_valid,
  input  logic                pred_taken,
  output logic                pred_ready,
  output logic [TAG_W-1:0]    pred_tag,
  input  logic                resolve_valid,
  input  logic [TAG_W-1:0]    resolve_tag,
  input  logic                resolve_mispredict,
  input  logic                resolve_taken,
  input  logic                retire_valid,
  input  logic                flush,
  output logic [HIST_LEN-1:0] spec_hist,
  output logic [HIST_LEN-1:0] arch_hist,
  output logic [TAG_W:0]      ckpt_count,
  output logic                full,
  output logic                empty
);

  localparam logic [TAG_W-1:0] TAG_ONE   = TAG_W'(1);
  localparam logic [TAG_W:0]   CNT_ONE   = (TAG_W+1)'(1);
  localparam logic [TAG_W:0]   CNT_DEPTH = (TAG_W+1)'(CKPT_DEPTH);

  // Registered state
  logic [HIST_LEN-1:0]   spec_q, arch_q;
  logic [TAG_W-1:0]      head_q, tail_q;
  logic [TAG_W:0]        count_q;
  logic [CKPT_DEPTH-1:0] ent_valid_q;
  logic [HIST_LEN-1:0]   ent_hist_q [CKPT_DEPTH];
  logic                  ent_out_q  [CKPT_DEPTH];

  // Next-state
  logic [HIST_LEN-1:0]   spec_d, arch_d;
  logic [TAG_W-1:0]      head_d, tail_d;
  logic [TAG_W:0]        count_d;
  logic [CKPT_DEPTH-1:0] ent_valid_d;

  // Decoded events
  logic             mispredict;   // raw hit, used to block predictions
  logic             mp_apply;     // mispredict that actually updates state
  logic             pred_fire;
  logic             retire_fire;
  logic             retire_bit;
  logic [TAG_W-1:0] squash_dist;  // age of the mispredicted entry relative to head
  logic [TAG_W:0]   squash_count; // occupancy after squashing younger entries

  function automatic logic [HIST_LEN-1:0] shift_in(input logic [HIST_LEN-1:0] h,
                                                   input logic                b);
    return {h[HIST_LEN-2:0], b};
  endfunction

  assign full       = (count_q == CNT_DEPTH);
  assign empty      = (count_q == '0);
  assign ckpt_count = count_q;
  assign pred_tag   = tail_q;
  assign spec_hist  = spec_q;
  assign arch_hist  = arch_q;

  assign mispredict   = resolve_valid && resolve_mispredict && ent_valid_q[resolve_tag];
  assign mp_apply     = mispredict && !flush;
  assign pred_ready   = !full && !flush && !mispredict;
  assign pred_fire    = pred_valid && pred_ready;
  assign retire_fire  = retire_valid && !empty && !flush;
  // A mispredict on the head entry in the same cycle supplies the corrected outcome.
  assign retire_bit   = (mispredict && (resolve_tag == head_q)) ? resolve_taken
                                                                : ent_out_q[head_q];
  // Power-of-two depth: tag subtraction wraps naturally to the distance from head.
  assign squash_dist  = resolve_tag - head_q;
  assign squash_count = {1'b0, squash_dist} + CNT_ONE;

  // Next-state for pointers, occupancy, histories and entry valid bits.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    spec_d      = spec_q;
    arch_d      = arch_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    ent_valid_d = ent_valid_q;

    if (flush) begin
      spec_d      = arch_q;
      head_d      = '0;
      tail_d      = '0;
      count_d     = '0;
      ent_valid_d = '0;
    end else begin
      if (mp_apply) begin
        spec_d  = shift_in(ent_hist_q[resolve_tag], resolve_taken);
        tail_d  = resolve_tag + TAG_ONE;
        count_d = squash_count;
        for (int i = 0; i < CKPT_DEPTH; i++) begin
          if (TAG_W'(TAG_W'(i) - head_q) > squash_dist) ent_valid_d[i] = 1'b0;
        end
      end else if (pred_fire) begin
        spec_d              = shift_in(spec_q, pred_taken);
        tail_d              = tail_q + TAG_ONE;
        count_d             = count_q + CNT_ONE;
        ent_valid_d[tail_q] = 1'b1;
      end

      if (retire_fire) begin
        arch_d              = shift_in(arch_q, retire_bit);
        head_d              = head_q + TAG_ONE;
        count_d             = count_d - CNT_ONE;
        ent_valid_d[head_q] = 1'b0;
      end
    end
  end

  // Control state register with asynchronous active-high reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spec_q      <= '0;
      arch_q      <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      ent_valid_q <= '0;
    end else begin
      spec_q      <= spec_d;
      arch_q      <= arch_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      ent_valid_q <= ent_valid_d;
    end
  end

  // Checkpoint payload storage: written on allocate, outcome patched on mispredict.
  // NOTE: payload storage is not reset; valid bits alone define which entries are meaningful.
  always_ff @(posedge clk) begin
    if (pred_fire) begin
      ent_hist_q[tail_q] <= spec_q;
      ent_out_q[tail_q]  <= pred_taken;
    end else if (mp_apply) begin
      ent_out_q[resolve_tag] <= resolve_taken;
    end
  end

endmodule

// File: tb/tb_ghr_checkpoint_queue.sv
// Scoreboard bench for ghr_checkpoint_queue (HIST_LEN=4, CKPT_DEPTH=4).
// The driver applies one cycle of stimulus, updates a queue-based reference
// model and pushes the expected response; a monitor pops and compares.
module tb_ghr_checkpoint_queue;

  localparam int HL = 4;
  localparam int CD = 4;
  localparam int TW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          pred_valid, pred_taken, pred_ready;
  logic [TW-1:0] pred_tag;
  logic          resolve_valid, resolve_mispredict, resolve_taken;
  logic [TW-1:0] resolve_tag;
  logic          retire_valid, flush;
  logic [HL-1:0] spec_hist, arch_hist;
  logic [TW:0]   ckpt_count;
  logic          full, empty;

  ghr_checkpoint_queue #(.HIST_LEN(HL), .CKPT_DEPTH(CD)) dut (
    .clk(clk), .reset(reset),
    .pred_valid(pred_valid), .pred_taken(pred_taken),
    .pred_ready(pred_ready), .pred_tag(pred_tag),
    .resolve_valid(resolve_valid), .resolve_tag(resolve_tag),
    .resolve_mispredict(resolve_mispredict), .resolve_taken(resolve_taken),
    .retire_valid(retire_valid), .flush(flush),
    .spec_hist(spec_hist), .arch_hist(arch_hist),
    .ckpt_count(ckpt_count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: live checkpoints held oldest-first in a queue.
  typedef struct {
    int   tag;
    int   hist;
    logic outcome;
  } ckpt_t;

  typedef struct {
    int rdy;
    int tag;
    int spec;
    int arch;
    int cnt;
  } exp_t;

  ckpt_t mq[$];
  int    m_spec, m_arch, m_tail;
  exp_t  exp_q[$];

  function automatic int sh(input int h, input logic b);
    return ((h * 2) + int'(b)) % (1 << HL);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_spec = 0;
    m_arch = 0;
    m_tail = 0;
  endtask

  // Drive one cycle of stimulus and record the expected response.
  task automatic cyc(input logic pv, input logic pt, input logic rv, input int rtag,
                     input logic rm, input logic rt, input logic ret, input logic fl);
    exp_t  e;
    int    k;
    logic  mp, rdy, ret_ok, rbit;
    ckpt_t c;
    @(negedge clk);
    pred_valid = pv; pred_taken = pt;
    resolve_valid = rv; resolve_tag = TW'(rtag);
    resolve_mispredict = rm; resolve_taken = rt;
    retire_valid = ret; flush = fl;

    k = -1;
    foreach (mq[i]) if (mq[i].tag == rtag) k = i;
    mp  = rv && rm && (k >= 0);
    rdy = (mq.size() != CD) && !fl && !mp;
    e.rdy = int'(rdy);
    e.tag = m_tail;
    rbit  = 1'b0;
    if (fl) begin
      m_spec = m_arch;
      mq.delete();
      m_tail = 0;
    end else begin
      ret_ok = ret && (mq.size() > 0);
      if (ret_ok) rbit = (mp && k == 0) ? rt : mq[0].outcome;
      if (mp) begin
        m_spec = sh(mq[k].hist, rt);
        mq[k].outcome = rt;
        while (mq.size() > k + 1) void'(mq.pop_back());
        m_tail = (rtag + 1) % CD;
      end else if (pv && rdy) begin
        c.tag = m_tail; c.hist = m_spec; c.outcome = pt;
        mq.push_back(c);
        m_spec = sh(m_spec, pt);
        m_tail = (m_tail + 1) % CD;
      end
      if (ret_ok) begin
        m_arch = sh(m_arch, rbit);
        void'(mq.pop_front());
      end
    end
    e.spec = m_spec;
    e.arch = m_arch;
    e.cnt  = mq.size();
    exp_q.push_back(e);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic predict(input logic t);
    cyc(1, t, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: combinational handshake sampled before the edge, state after it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pred_ready", int'(pred_ready), e.rdy);
        check("pred_tag",   int'(pred_tag),   e.tag);
        @(posedge clk);
        #1;
        check("spec_hist",  int'(spec_hist),  e.spec);
        check("arch_hist",  int'(arch_hist),  e.arch);
        check("ckpt_count", int'(ckpt_count), e.cnt);
        check("full",       int'(full),       int'(e.cnt == CD));
        check("empty",      int'(empty),      int'(e.cnt == 0));
      end
    end
  end

  task automatic check_reset_state();
    check("rst_spec",  int'(spec_hist),  0);
    check("rst_arch",  int'(arch_hist),  0);
    check("rst_count", int'(ckpt_count), 0);
    check("rst_empty", int'(empty),      1);
    check("rst_full",  int'(full),       0);
    check("rst_ready", int'(pred_ready), 1);
    check("rst_tag",   int'(pred_tag),   0);
  endtask

  task automatic mid_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check_reset_state();
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int tag;
    reset = 1'b0;
    pred_valid = 0; pred_taken = 0; resolve_valid = 0; resolve_tag = '0;
    resolve_mispredict = 0; resolve_taken = 0; retire_valid = 0; flush = 0;
    model_reset();
    #3 reset = 1'b1;
    #4 check_reset_state();
    @(negedge clk);
    reset = 1'b0;

    // Fill: T,N,T,T then a blocked fifth prediction.
    predict(1); predict(0); predict(1); predict(1);
    predict(0);
    // Mispredict tag 1 with taken, then a resolve on squashed tag 3.
    cyc(0, 0, 1, 1, 1, 1, 0, 0);
    cyc(0, 0, 1, 3, 1, 0, 0, 0);
    // Retire twice, then a retire on empty.
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    // Wrap: alternating predict / retire.
    for (int i = 0; i < 6; i++) begin
      predict(i[0]);
      cyc(0, 0, 0, 0, 0, 0, 1, 0);
    end
    // Flush with simultaneous retire and prediction.
    mid_reset();
    predict(1); predict(1); predict(0);
    cyc(1, 1, 0, 0, 0, 0, 1, 1);
    idle();
    // Retire and mispredict on the head entry in the same cycle (bypass).
    predict(0); predict(1);
    cyc(0, 0, 1, 0, 1, 1, 1, 0);
    // Retire plus predict on a non-full queue.
    cyc(1, 1, 0, 0, 0, 0, 1, 0);
    // Predict while full with a retire the same cycle.
    predict(0); predict(1); predict(1);
    cyc(1, 0, 0, 0, 0, 0, 1, 0);
    idle();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if (mq.size() > 0 && $urandom_range(0, 9) < 7)
        tag = mq[$urandom_range(0, mq.size() - 1)].tag;
      else
        tag = int'($urandom_range(0, CD - 1));
      cyc(logic'($urandom_range(0, 9) < 6), logic'($urandom_range(0, 1)),
          logic'($urandom_range(0, 9) < 3), tag,
          logic'($urandom_range(0, 9) < 7), logic'($urandom_range(0, 1)),
          logic'($urandom_range(0, 9) < 4), logic'($urandom_range(0, 99) < 3));
    end
    idle();
    idle();

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #2;
    check("scoreboard_drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
